fill_dpram: RTL and testbench
=============================

# fill_dpram

Single-clock, parametrised dual-port RAM: one read port, one byte-enabled write port, configurable read latency and read-during-write policy, plus a built-in fill engine that sweeps every entry to a constant, one entry per cycle. Reset and software-initiated clears run through that engine, so the array maps to block RAM instead of a flop array with a parallel reset. Used for framebuffers, line buffers and palette tables where a whole-array clear is needed.

## Interface
- DATA_WIDTH, 16: word width in bits; must be a multiple of 8.
- DATA_N, 16: number of words; need not be a power of two.
- ADDR_BITS, $clog2(DATA_N): address width.
- RST_VAL, 0: fill value used by reset.
- RD_LATENCY, 1: read latency in cycles; legal values are 1 and 2.
- RDW_MODE, RDW_WRITE_FIRST: same-address read/write policy; enum from fill_dpram_pkg.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous, active-high. Starts a fill with RST_VAL.
- fill_start  in  1  starts a fill with fill_val.
- fill_val  in  DATA_WIDTH  fill value, sampled with fill_start.
- busy  out  1  fill in progress.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_BITS  read address.
- rd_out  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_out carries new data this cycle.
- wr_en  in  1  write request.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers byte i, LSB first.
- wr_addr  in  ADDR_BITS  write address.
- wr_in  in  DATA_WIDTH  write data.
- wr_drop  out  1  one-cycle pulse: a write was rejected.

## Operation
- Fill engine states: IDLE and FILL.
  - IDLE -> FILL on an edge sampling rst or fill_start. The fill value latches at that edge; the counter is set to 0.
  - rst has priority over fill_start when both are high.
  - In FILL, each edge writes the fill value to the address in the counter, then increments the counter.
  - FILL -> IDLE on the edge that writes address DATA_N-1.
  - rst or fill_start sampled during FILL restarts the sweep at 0 with the new value.
- User writes:
  - With wr_en=1 and busy=0, bytes whose wr_be bit is 1 are updated; all other bytes are kept.
  - With wr_en=1 and busy=1, the write is discarded and wr_drop=1 for the next cycle.
  - A write sampled on the same edge as rst or fill_start executes; the later sweep overwrites it.
  - wr_addr >= DATA_N: write ignored, wr_drop is not asserted.
- Reads:
  - Allowed at all times, including during FILL; they return current array contents, so a partially filled array is visible.
  - rd_addr >= DATA_N returns 0.
  - rd_out holds its last value while rd_en=0.
- Read-during-write (same address, same edge; fill writes count as writes):
  - RDW_WRITE_FIRST: rd_out returns the byte-merged new word.
  - RDW_READ_FIRST: rd_out returns the old word.

## Timing
- Reset values: busy=1 on the cycle after an rst edge; rd_out=0, rd_valid=0, wr_drop=0.
- rst also flushes the read pipeline.
- Fill duration: busy is high for exactly DATA_N cycles after the start edge E0. Address k is written at edge E(k+1). busy falls after E(DATA_N).
- Read latency:
  - RD_LATENCY=1: rd_out and rd_valid update on the edge that samples rd_en.
  - RD_LATENCY=2: one extra register stage; the rd_valid pipeline has the same depth as the data path.
  - Back-to-back reads give one result per cycle.
- wr_drop is registered: it is high in the cycle after the rejected write is sampled.
- Holding rst high keeps restarting the fill; the sweep completes DATA_N cycles after rst deasserts.

## Structure
- fill_dpram_pkg holds:
  - rdw_mode_e enum: RDW_WRITE_FIRST, RDW_READ_FIRST.
  - fill_state_e enum: IDLE, FILL.
  - a byte-merge function shared by the write path and the write-first bypass.
- One sub-module, fill_seq: state register, counter, latched fill value; outputs busy, fill_we, fill_addr, fill_data.
- Top level muxes fill and user writes into the single array write port, then adds the read pipeline and the bypass.
- Elaboration-time checks: DATA_WIDTH % 8 == 0 and RD_LATENCY in {1,2}.

## Test plan
1. Reset with DATA_N=16, RST_VAL=0: rst one cycle -> busy high exactly 16 cycles; then reads of all 16 addresses return 0; wr_drop stays 0.
2. Byte enables: with busy low, write 0xABCD with wr_be=2'b11 to addr 3, then write 0x1200 with wr_be=2'b10 -> read of addr 3 returns 0x12CD.
3. Write during fill: fill_start with fill_val=0x5555, write 0xFFFF to addr 2 at cycle 3 of the fill -> wr_drop pulses one cycle; addr 2 reads 0x5555.
4. Restart: fill_start with 0x1111, then fill_start with 0x2222 at cycle 5 of the fill -> busy stays high 16 cycles after the second start; all entries read 0x2222. rst and fill_start high together -> RST_VAL wins.
5. Read-during-write: addr 7 holds 0x0001; write 0x0002 to addr 7 and read addr 7 on the same edge -> WRITE_FIRST returns 0x0002, READ_FIRST returns 0x0001. Run with RD_LATENCY=1 and 2; data appears 1 and 2 cycles later respectively, aligned with rd_valid.
6. Non-power-of-two DATA_N=10: fill -> busy high 10 cycles; write to addr 12 is ignored with no wr_drop; read of addr 12 returns 0.

Source files
------------

// File: rtl/fill_dpram_pkg.sv
// Shared types and helpers for the fill_dpram RAM and its fill sequencer.
package fill_dpram_pkg;

  typedef enum logic {
    RDW_WRITE_FIRST = 1'b0,
    RDW_READ_FIRST  = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // Widest word the byte-merge helper handles; callers zero-extend into it.
  localparam int unsigned MERGE_MAX_W  = 512;
  localparam int unsigned MERGE_MAX_BE = MERGE_MAX_W / 8;

  // Replace each byte of old_word whose enable bit is set with the same byte of new_word.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]  old_word,
    input logic [MERGE_MAX_W-1:0]  new_word,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < MERGE_MAX_BE; i++) begin
      if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/fill_dpram_seq.sv
// Fill sequencer: sweeps the RAM one address per cycle with a latched constant.
module fill_seq
  import fill_dpram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DATA_N     = 16,
  parameter int                    ADDR_BITS  = $clog2(DATA_N),
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_start_val,
  output logic                  o_busy,
  output logic                  o_fill_we,
  output logic [ADDR_BITS-1:0]  o_fill_addr,
  output logic [DATA_WIDTH-1:0] o_fill_data
);

  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DATA_N - 1);

  fill_state_e           r_state;
  logic [ADDR_BITS-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_val;

  // Start/restart on rst or i_start (rst wins), otherwise advance one address per cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_val   <= RST_VAL;
    end else if (i_start) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_val   <= i_start_val;
    end else if (r_state == FILL) begin
      if (r_cnt == LAST) r_state <= IDLE;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_busy      = (r_state == FILL);
  assign o_fill_we   = (r_state == FILL);
  assign o_fill_addr = r_cnt;
  assign o_fill_data = r_val;

endmodule

// File: rtl/fill_dpram.sv
// Dual-port RAM (1 read, 1 byte-enabled write) with a sweep-based fill/clear engine.
module fill_dpram
  import fill_dpram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DATA_N     = 16,
  parameter int                    ADDR_BITS  = $clog2(DATA_N),
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0,
  parameter int                    RD_LATENCY = 1,
  parameter rdw_mode_e             RDW_MODE   = RDW_WRITE_FIRST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fill_start,
  input  logic [DATA_WIDTH-1:0]   fill_val,
  output logic                    busy,
  input  logic                    rd_en,
  input  logic [ADDR_BITS-1:0]    rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_out,
  output logic                    rd_valid,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [ADDR_BITS-1:0]    wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_in,
  output logic                    wr_drop
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [ADDR_BITS:0] N_EXT = (ADDR_BITS + 1)'(DATA_N);

  if (DATA_WIDTH % 8 != 0) begin : g_chk_width
    $error("fill_dpram: DATA_WIDTH must be a multiple of 8");
  end
  if (DATA_WIDTH > MERGE_MAX_W) begin : g_chk_max_width
    $error("fill_dpram: DATA_WIDTH exceeds byte_merge capacity");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_chk_lat
    $error("fill_dpram: RD_LATENCY must be 1 or 2");
  end
  if (DATA_N < 2) begin : g_chk_depth
    $error("fill_dpram: DATA_N must be at least 2");
  end

  function automatic logic [DATA_WIDTH-1:0] merge_w(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_W-1:0]       be
  );
    return DATA_WIDTH'(byte_merge(MERGE_MAX_W'(old_word), MERGE_MAX_W'(new_word),
                                  MERGE_MAX_BE'(be)));
  endfunction

  logic                  w_busy;
  logic                  w_fill_we;
  logic [ADDR_BITS-1:0]  w_fill_addr;
  logic [DATA_WIDTH-1:0] w_fill_data;

  fill_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_N     (DATA_N),
    .ADDR_BITS  (ADDR_BITS),
    .RST_VAL    (RST_VAL)
  ) u_seq (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (fill_start),
    .i_start_val (fill_val),
    .o_busy      (w_busy),
    .o_fill_we   (w_fill_we),
    .o_fill_addr (w_fill_addr),
    .o_fill_data (w_fill_data)
  );

  assign busy = w_busy;

  logic w_wr_in_range;
  logic w_rd_in_range;
  logic w_user_we;

  assign w_wr_in_range = ({1'b0, wr_addr} < N_EXT);
  assign w_rd_in_range = ({1'b0, rd_addr} < N_EXT);
  assign w_user_we     = wr_en & ~w_busy & w_wr_in_range;

  logic                  w_we;
  logic [ADDR_BITS-1:0]  w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [BE_W-1:0]       w_wbe;

  // Single array write port: the sweep owns it while busy, user writes otherwise.
  always_comb begin
    w_we    = w_fill_we | w_user_we;
    w_waddr = wr_addr;
    w_wdata = wr_in;
    w_wbe   = wr_be;
    if (w_fill_we) begin
      w_waddr = w_fill_addr;
      w_wdata = w_fill_data;
      w_wbe   = '1;
    end
  end

  logic [DATA_WIDTH-1:0] r_mem [DATA_N];

  // Array write, byte-merged into the existing word; no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= merge_w(r_mem[w_waddr], w_wdata, w_wbe);
  end

  logic                  r_v1;
  logic [DATA_WIDTH-1:0] r_raw;
  logic                  r_hit;
  logic [DATA_WIDTH-1:0] r_bdata;
  logic [BE_W-1:0]       r_bbe;
  logic [DATA_WIDTH-1:0] w_rd1;

  // First read stage: raw array word plus captured same-address write for the bypass.
  // The merge is applied after the register so the memory output stays a plain read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_raw   <= '0;
      r_hit   <= 1'b0;
      r_bdata <= '0;
      r_bbe   <= '0;
    end else begin
      r_v1 <= rd_en;
      if (rd_en) begin
        r_raw   <= w_rd_in_range ? r_mem[rd_addr] : '0;
        r_hit   <= (RDW_MODE == RDW_WRITE_FIRST) && w_we && w_rd_in_range &&
                   (w_waddr == rd_addr);
        r_bdata <= w_wdata;
        r_bbe   <= w_wbe;
      end
    end
  end

  assign w_rd1 = r_hit ? merge_w(r_raw, r_bdata, r_bbe) : r_raw;

  if (RD_LATENCY == 1) begin : g_lat1
    assign rd_out   = w_rd1;
    assign rd_valid = r_v1;
  end else begin : g_lat2
    logic                  r_v2;
    logic [DATA_WIDTH-1:0] r_rd2;

    // Second read stage, advancing only when stage one carries a new result.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v2  <= 1'b0;
        r_rd2 <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) r_rd2 <= w_rd1;
      end
    end

    assign rd_out   = r_rd2;
    assign rd_valid = r_v2;
  end

  logic r_drop;

  // Flag in-range user writes that arrived while the sweep owned the write port.
  always_ff @(posedge clk) begin
    if (rst) r_drop <= 1'b0;
    else     r_drop <= wr_en & w_busy & w_wr_in_range;
  end

  assign wr_drop = r_drop;

endmodule

// File: tb/tb_fill_dpram.sv
// Directed bench for fill_dpram: five instances share one stimulus stream.
// 0: WF/lat1/N16  1: RF/lat1/N16  2: WF/lat2/N16  3: RF/lat2/N16  4: WF/lat1/N10 RST_VAL=00A5
module tb_fill_dpram;
  import fill_dpram_pkg::*;

  logic        clk = 1'b0;
  logic        rst, fill_start, rd_en, wr_en;
  logic [15:0] fill_val, wr_in;
  logic [3:0]  rd_addr, wr_addr;
  logic [1:0]  wr_be;
  logic [4:0]  busy, rd_valid, wr_drop;
  logic [15:0] rd_out [5];

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] q1 [5];
  logic [15:0] q2 [5];
  logic [4:0]  v1, v2;

  always #5 clk = ~clk;

  fill_dpram #(.DATA_WIDTH(16), .DATA_N(16), .RST_VAL(16'h0000), .RD_LATENCY(1),
               .RDW_MODE(RDW_WRITE_FIRST)) u_d0 (
    .clk(clk), .rst(rst), .fill_start(fill_start), .fill_val(fill_val), .busy(busy[0]),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_out(rd_out[0]), .rd_valid(rd_valid[0]),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_in(wr_in), .wr_drop(wr_drop[0]));
  fill_dpram #(.DATA_WIDTH(16), .DATA_N(16), .RST_VAL(16'h0000), .RD_LATENCY(1),
               .RDW_MODE(RDW_READ_FIRST)) u_d1 (
    .clk(clk), .rst(rst), .fill_start(fill_start), .fill_val(fill_val), .busy(busy[1]),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_out(rd_out[1]), .rd_valid(rd_valid[1]),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_in(wr_in), .wr_drop(wr_drop[1]));
  fill_dpram #(.DATA_WIDTH(16), .DATA_N(16), .RST_VAL(16'h0000), .RD_LATENCY(2),
               .RDW_MODE(RDW_WRITE_FIRST)) u_d2 (
    .clk(clk), .rst(rst), .fill_start(fill_start), .fill_val(fill_val), .busy(busy[2]),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_out(rd_out[2]), .rd_valid(rd_valid[2]),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_in(wr_in), .wr_drop(wr_drop[2]));
  fill_dpram #(.DATA_WIDTH(16), .DATA_N(16), .RST_VAL(16'h0000), .RD_LATENCY(2),
               .RDW_MODE(RDW_READ_FIRST)) u_d3 (
    .clk(clk), .rst(rst), .fill_start(fill_start), .fill_val(fill_val), .busy(busy[3]),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_out(rd_out[3]), .rd_valid(rd_valid[3]),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_in(wr_in), .wr_drop(wr_drop[3]));
  fill_dpram #(.DATA_WIDTH(16), .DATA_N(10), .RST_VAL(16'h00A5), .RD_LATENCY(1),
               .RDW_MODE(RDW_WRITE_FIRST)) u_d4 (
    .clk(clk), .rst(rst), .fill_start(fill_start), .fill_val(fill_val), .busy(busy[4]),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_out(rd_out[4]), .rd_valid(rd_valid[4]),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_in(wr_in), .wr_drop(wr_drop[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_in = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) q1[i] = rd_out[i];
    v1 = rd_valid;
    tick();
    for (int i = 0; i < 5; i++) q2[i] = rd_out[i];
    v2 = rd_valid;
  endtask

  task automatic read_all(input logic [3:0] a, input logic [15:0] e16, input logic [15:0] e10);
    logic [15:0] want;
    do_read(a);
    for (int i = 0; i < 5; i++) begin
      want = (i == 4) ? e10 : e16;
      check($sformatf("rd_d%0d_a%0d", i, a), (i == 2 || i == 3) ? q2[i] : q1[i], want);
    end
    check($sformatf("rdv_lat1_a%0d", a), v1, 5'b10011);
    check($sformatf("rdv_lat2_a%0d", a), v2, 5'b01100);
    check($sformatf("rd_hold_a%0d", a), q2[0], e16);
  endtask

  task automatic count_busy(input string tag, input int e16, input int e10);
    int   c16 = 0;
    int   c10 = 0;
    int   g   = 0;
    logic drop_seen = 1'b0;
    while ((busy[0] || busy[4]) && g < 100) begin
      if (busy[0]) c16++;
      if (busy[4]) c10++;
      drop_seen |= |wr_drop;
      g++;
      tick();
    end
    check({tag, "_busy_n16"}, c16, e16);
    check({tag, "_busy_n10"}, c10, e10);
    check({tag, "_no_drop"}, drop_seen, 1'b0);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((|busy) && g < 100) begin
      g++;
      tick();
    end
    check("idle_reached", |busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; fill_start = 1'b0; fill_val = '0; rd_en = 1'b0; rd_addr = '0;
    wr_en = 1'b0; wr_be = '0; wr_addr = '0; wr_in = '0;

    // Reset: busy for DATA_N cycles, array cleared to RST_VAL
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 5'b11111);
    check("rst_rd_valid", rd_valid, 5'b00000);
    check("rst_wr_drop", wr_drop, 5'b00000);
    check("rst_rd_out", rd_out[0], 16'h0000);
    count_busy("rst", 16, 10);
    for (int a = 0; a < 16; a++) read_all(4'(a), 16'h0000, (a < 10) ? 16'h00A5 : 16'h0000);

    // Byte enables
    do_write(4'd3, 16'hABCD, 2'b11);
    do_write(4'd3, 16'h1200, 2'b10);
    check("be_no_drop", wr_drop, 5'b00000);
    read_all(4'd3, 16'h12CD, 16'h12CD);
    do_write(4'd3, 16'h00EF, 2'b01);
    read_all(4'd3, 16'h12EF, 16'h12EF);

    // Read-during-write, full word
    do_write(4'd7, 16'h0001, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd7; wr_in = 16'h0002; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("rdw_wf_lat1", rd_out[0], 16'h0002);
    check("rdw_rf_lat1", rd_out[1], 16'h0001);
    check("rdw_wf_n10", rd_out[4], 16'h0002);
    check("rdw_v_first", rd_valid, 5'b10011);
    tick();
    check("rdw_wf_lat2", rd_out[2], 16'h0002);
    check("rdw_rf_lat2", rd_out[3], 16'h0001);
    check("rdw_v_second", rd_valid, 5'b01100);
    check("rdw_wf_lat1_hold", rd_out[0], 16'h0002);

    // Read-during-write, partial bytes: bypass must merge
    wr_en = 1'b1; wr_addr = 4'd7; wr_in = 16'hAB00; wr_be = 2'b10;
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("rdwbe_wf_lat1", rd_out[0], 16'hAB02);
    check("rdwbe_rf_lat1", rd_out[1], 16'h0002);
    tick();
    check("rdwbe_wf_lat2", rd_out[2], 16'hAB02);
    check("rdwbe_rf_lat2", rd_out[3], 16'h0002);

    // Back-to-back reads: one result per cycle
    rd_en = 1'b1; rd_addr = 4'd3;
    tick(); rd_addr = 4'd7;
    check("b2b_l1_0", rd_out[0], 16'h12EF);
    check("b2b_l1_v0", rd_valid[0], 1'b1);
    tick(); rd_addr = 4'd0;
    check("b2b_l1_1", rd_out[0], 16'hAB02);
    check("b2b_l2_0", rd_out[2], 16'h12EF);
    check("b2b_l2_v0", rd_valid[2], 1'b1);
    tick(); rd_en = 1'b0;
    check("b2b_l1_2", rd_out[0], 16'h0000);
    check("b2b_l2_1", rd_out[2], 16'hAB02);
    tick();
    check("b2b_l2_2", rd_out[2], 16'h0000);
    check("b2b_l1_vend", rd_valid[0], 1'b0);

    // Write during fill is dropped; partial fill is visible to reads
    fill_val = 16'h5555; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick(); tick();
    do_write(4'd2, 16'hFFFF, 2'b11);
    check("drop_pulse_n16", wr_drop[0], 1'b1);
    check("drop_pulse_n10", wr_drop[4], 1'b1);
    tick();
    check("drop_clear", wr_drop[0], 1'b0);
    read_all(4'd5, 16'h0000, 16'h00A5);
    read_all(4'd0, 16'h5555, 16'h5555);
    wait_idle();
    read_all(4'd2, 16'h5555, 16'h5555);

    // Restart mid-fill
    fill_val = 16'h1111; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    repeat (4) tick();
    fill_val = 16'h2222; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    count_busy("restart", 16, 10);
    for (int a = 0; a < 16; a++) read_all(4'(a), 16'h2222, (a < 10) ? 16'h2222 : 16'h0000);

    // rst and fill_start together: RST_VAL wins, read pipeline flushed
    rst = 1'b1; fill_start = 1'b1; fill_val = 16'h7777;
    tick();
    rst = 1'b0; fill_start = 1'b0;
    check("rstfs_busy", busy, 5'b11111);
    check("rstfs_rd_valid", rd_valid, 5'b00000);
    check("rstfs_wr_drop", wr_drop, 5'b00000);
    check("rstfs_flush_lat1", rd_out[0], 16'h0000);
    check("rstfs_flush_lat2", rd_out[2], 16'h0000);
    count_busy("rstfs", 16, 10);
    read_all(4'd5, 16'h0000, 16'h00A5);
    read_all(4'd9, 16'h0000, 16'h00A5);

    // Out-of-range addresses on the DATA_N=10 instance
    do_write(4'd12, 16'hBEEF, 2'b11);
    check("oor_idle_nodrop_n10", wr_drop[4], 1'b0);
    check("inr_idle_nodrop_n16", wr_drop[0], 1'b0);
    read_all(4'd12, 16'hBEEF, 16'h0000);
    fill_val = 16'h3333; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    do_write(4'd12, 16'hFFFF, 2'b11);
    check("oor_busy_nodrop_n10", wr_drop[4], 1'b0);
    check("inr_busy_drop_n16", wr_drop[0], 1'b1);
    wait_idle();
    read_all(4'd12, 16'h3333, 16'h0000);
    read_all(4'd9, 16'h3333, 16'h3333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
